aux_arbiter: RTL and testbench
==============================

# aux_arbiter

Shares the write/read AUX register bus (implied 0xE0 address prefix) between several masters: copper, CPU hwregs bridge, blitter and others. Copper-class masters get strict priority; the remaining masters are served round-robin. One transaction is in flight at a time. A watchdog completes any transaction the target never acknowledges, so a missing peripheral cannot stall the copper or the CPU.

## Interface
Parameters:
- NUM_REQ, 4: number of requesting masters (2..8).
- RT_MASK, 4'b0001: bit i set marks master i as realtime (strict priority); default marks master 0, the copper.
- TIMEOUT_CYCLES, 1023: cycles in ACTIVE without aux_ack before forced completion (≥2).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req_request  in  NUM_REQ  per-master request; held with address/data stable until that master's ack
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_address  in  NUM_REQ×24  per-master AUX address
- req_wdata  in  NUM_REQ×32  per-master write data
- req_ack  out  NUM_REQ  one-cycle completion pulse, at most one bit set
- req_rdata  out  32  read data, valid only in the req_ack cycle
- aux_request  out  1  transaction to target
- aux_write  out  1  direction to target
- aux_address  out  24  target address
- aux_wdata  out  32  target write data
- aux_ack  in  1  one-cycle target completion pulse
- aux_rdata  in  32  target read data, valid with aux_ack
- timeout_error  out  1  sticky; set on any watchdog completion
- timeout_clear  in  1  clears timeout_error

## Operation
- State machine IDLE → ACTIVE → DONE → IDLE.
- IDLE:
  - If any req_request is set, pick a winner and latch grant, write, address and wdata into registers.
  - Set aux_request; go to ACTIVE.
- Winner selection:
  - The lowest-index set request within RT_MASK wins.
  - Otherwise, round-robin among non-RT masters, starting at the index after the last granted non-RT master (rr_ptr). rr_ptr updates only on non-RT grants.
- ACTIVE:
  - aux_* outputs are driven from the latched registers and stay stable.
  - On aux_ack: latch aux_rdata, drop aux_request, pulse req_ack[grant]; go to DONE.
  - When the watchdog counter reaches TIMEOUT_CYCLES with no ack: same actions, but rdata = 32'hDEADBEEF and timeout_error is set; go to DONE.
- DONE:
  - req_ack and req_rdata are presented for exactly this cycle.
  - All requests are ignored this cycle, because the acked master's request may still be high.
  - Return to IDLE.
- Writes also return rdata (aux_rdata or DEADBEEF); masters ignore it.
- timeout_clear and a new timeout in the same cycle: set wins.
- A master dropping its request while ACTIVE does not abort the transaction. Its ack is still pulsed.

## Timing
- Reset values: aux_request 0, aux_write 0, aux_address 0, aux_wdata 0, req_ack 0, req_rdata 0, timeout_error 0, state IDLE, rr_ptr 0, watchdog 0.
- All outputs are registered.
- Request rising at cycle N (state IDLE) → aux_request high at N+1.
- aux_ack at cycle M → aux_request low and req_ack pulse at M+1.
- Next grant is evaluated at M+2; aux_request for it is high at M+3.
- Back-to-back throughput: one transaction per (target latency + 3) cycles.
- Watchdog counts from 0 on entry to ACTIVE and increments every ACTIVE cycle. At count == TIMEOUT_CYCLES it forces completion at the next edge.
- aux_ack arriving in the same cycle as the timeout: ack wins, real data is returned, no error.
- aux_ack seen outside ACTIVE is ignored.
- Reset mid-transaction abandons it: no ack is issued and all registers return to reset values the next cycle.

## Structure
- Package aux_pkg:
  - AUX_ADDR_W = 24, AUX_DATA_W = 32.
  - AUX_TIMEOUT_DATA = 32'hDEADBEEF.
  - typedef enum logic [1:0] {ARB_IDLE, ARB_ACTIVE, ARB_DONE} aux_arb_state_t.
- Sub-module aux_rr_select is purely combinational and natural to factor out.
  - Inputs: request vector, RT mask, rr_ptr.
  - Outputs: grant index and a valid flag.
- Everything else lives in aux_arbiter.

## Test plan
- Single write:
  - Stimulus: master 2 writes addr 24'h000100, data 32'h12345678; target acks after 3 cycles.
  - Response: aux_request high the cycle after the request, fields match, req_ack[2] pulses once, no other ack.
- RT priority:
  - Stimulus: masters 0 and 1 request in the same cycle; both re-request immediately after each ack.
  - Response: master 0 is granted first; master 1 is granted only when master 0's request is not pending in IDLE.
- Round-robin:
  - Stimulus: masters 1, 2 and 3 continuously request reads; target returns addr-based data.
  - Response: grant order is 1, 2, 3, 1, 2, 3; each req_rdata matches its master's address.
- Timeout:
  - Stimulus: target never acks a read from master 3.
  - Response: after TIMEOUT_CYCLES, req_ack[3] with rdata 32'hDEADBEEF and timeout_error = 1; it stays set until timeout_clear is asserted.
- Ack-at-timeout tie:
  - Stimulus: aux_ack arrives at count == TIMEOUT_CYCLES.
  - Response: real data is returned and timeout_error stays 0.
- Reset mid-ACTIVE:
  - Stimulus: assert reset while master 1 is ACTIVE.
  - Response: next cycle all outputs are 0, no req_ack is issued, and a fresh request is served normally afterwards.

Source files
------------

// File: rtl/aux_pkg.sv
// Shared constants and types for the AUX register bus arbiter.
// The 0xE0 address prefix is implied by the bus and is not carried here.
package aux_pkg;

    localparam int AUX_ADDR_W = 24;
    localparam int AUX_DATA_W = 32;

    // Read data returned when the watchdog forces a transaction to complete.
    localparam logic [AUX_DATA_W-1:0] AUX_TIMEOUT_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACTIVE,
        ARB_DONE
    } aux_arb_state_t;

    // Width of an index able to address n masters.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aux_rr_select.sv
// Combinational winner selection: realtime masters by fixed priority,
// then the other masters in round-robin order starting at rr_ptr.
module aux_rr_select
    import aux_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] request,
    input  logic [NUM_REQ-1:0] rt_mask,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               valid
);

    logic [IDX_W:0]   slot;
    logic [IDX_W-1:0] idx;

    // The round-robin scan only runs when no realtime master claimed the bus.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        slot  = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && rt_mask[i] && request[i]) begin
                grant = IDX_W'(i);
                valid = 1'b1;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            slot = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (slot >= (IDX_W+1)'(NUM_REQ)) begin
                slot = slot - (IDX_W+1)'(NUM_REQ);
            end
            idx = slot[IDX_W-1:0];
            if (!valid && !rt_mask[idx] && request[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aux_arbiter.sv
// Shares the AUX register bus between several masters, one transaction at a
// time, with a watchdog that completes transactions the target never acks.
module aux_arbiter
    import aux_pkg::*;
#(
    parameter int                 NUM_REQ        = 4,
    parameter logic [NUM_REQ-1:0] RT_MASK        = 4'b0001,
    parameter int                 TIMEOUT_CYCLES = 1023
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_request,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*AUX_ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*AUX_DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [AUX_DATA_W-1:0]         req_rdata,
    output logic                          aux_request,
    output logic                          aux_write,
    output logic [AUX_ADDR_W-1:0]         aux_address,
    output logic [AUX_DATA_W-1:0]         aux_wdata,
    input  logic                          aux_ack,
    input  logic [AUX_DATA_W-1:0]         aux_rdata,
    output logic                          timeout_error,
    input  logic                          timeout_clear
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    aux_arb_state_t  state;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] rr_ptr;
    logic [WD_W-1:0]  watchdog;

    logic [IDX_W-1:0]      sel_grant;
    logic                  sel_valid;
    logic                  sel_write;
    logic [AUX_ADDR_W-1:0] sel_address;
    logic [AUX_DATA_W-1:0] sel_wdata;
    logic [IDX_W-1:0]      ptr_next;
    logic                  timed_out;

    aux_rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_select (
        .request (req_request),
        .rt_mask (RT_MASK),
        .rr_ptr  (rr_ptr),
        .grant   (sel_grant),
        .valid   (sel_valid)
    );

    // Route the selected master's transaction fields toward the latch.
    always_comb begin
        sel_write   = 1'b0;
        sel_address = '0;
        sel_wdata   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_grant == IDX_W'(i)) begin
                sel_write   = req_write[i];
                sel_address = req_address[i*AUX_ADDR_W +: AUX_ADDR_W];
                sel_wdata   = req_wdata[i*AUX_DATA_W +: AUX_DATA_W];
            end
        end
    end

    always_comb begin
        ptr_next  = (sel_grant == IDX_W'(NUM_REQ - 1)) ? '0 : sel_grant + IDX_W'(1);
        timed_out = (state == ARB_ACTIVE) && !aux_ack && (watchdog == WD_W'(TIMEOUT_CYCLES));
    end

    // A real ack in the timeout cycle takes precedence over the watchdog.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ARB_IDLE;
            grant         <= '0;
            rr_ptr        <= '0;
            watchdog      <= '0;
            aux_request   <= 1'b0;
            aux_write     <= 1'b0;
            aux_address   <= '0;
            aux_wdata     <= '0;
            req_ack       <= '0;
            req_rdata     <= '0;
            timeout_error <= 1'b0;
        end else begin
            req_ack   <= '0;
            req_rdata <= '0;
            case (state)
                ARB_IDLE: begin
                    if (sel_valid) begin
                        grant       <= sel_grant;
                        aux_write   <= sel_write;
                        aux_address <= sel_address;
                        aux_wdata   <= sel_wdata;
                        aux_request <= 1'b1;
                        watchdog    <= '0;
                        state       <= ARB_ACTIVE;
                        if (!RT_MASK[sel_grant]) begin
                            rr_ptr <= ptr_next;
                        end
                    end
                end
                ARB_ACTIVE: begin
                    if (aux_ack || timed_out) begin
                        aux_request <= 1'b0;
                        req_ack     <= NUM_REQ'(1) << grant;
                        req_rdata   <= aux_ack ? aux_rdata : AUX_TIMEOUT_DATA;
                        state       <= ARB_DONE;
                    end else begin
                        watchdog <= watchdog + WD_W'(1);
                    end
                end
                ARB_DONE: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
            if (timed_out) begin
                timeout_error <= 1'b1;
            end else if (timeout_clear) begin
                timeout_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aux_arbiter.sv
// Self-checking bench for aux_arbiter: a transaction-level model checked every
// cycle, plus directed scenarios with hand-computed grant orders and data.
module tb_aux_arbiter;

    localparam int          NUM_REQ = 4;
    localparam logic [3:0]  RT_MASK = 4'b0001;
    localparam int          TIMEOUT = 20;

    logic          clock;
    logic          reset;
    logic [3:0]    req_request;
    logic [3:0]    req_write;
    logic [95:0]   req_address;
    logic [127:0]  req_wdata;
    logic [3:0]    req_ack;
    logic [31:0]   req_rdata;
    logic          aux_request;
    logic          aux_write;
    logic [23:0]   aux_address;
    logic [31:0]   aux_wdata;
    logic          aux_ack;
    logic [31:0]   aux_rdata;
    logic          timeout_error;
    logic          timeout_clear;

    aux_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .RT_MASK        (RT_MASK),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_request   (req_request),
        .req_write     (req_write),
        .req_address   (req_address),
        .req_wdata     (req_wdata),
        .req_ack       (req_ack),
        .req_rdata     (req_rdata),
        .aux_request   (aux_request),
        .aux_write     (aux_write),
        .aux_address   (aux_address),
        .aux_wdata     (aux_wdata),
        .aux_ack       (aux_ack),
        .aux_rdata     (aux_rdata),
        .timeout_error (timeout_error),
        .timeout_clear (timeout_clear)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int tgt_lat = 3;
    bit tgt_en = 1'b1;
    bit force_ack = 1'b0;
    int tgt_cnt = 0;
    int m_left[4];

    int          grant_log[$];
    logic [31:0] rdata_log[$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: simulation did not end, required end before 300000");
        $fatal(1, "[TB] global timeout");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input int m, input logic wr, input logic [23:0] addr,
                                  input logic [31:0] wd, input int count);
        req_write[m]             = wr;
        req_address[m*24 +: 24]  = addr;
        req_wdata[m*32 +: 32]    = wd;
        m_left[m]                = count;
        req_request[m]           = 1'b1;
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int  n;
        bit  quiet;
        n = 0;
        quiet = 1'b0;
        while (!quiet && n < budget) begin
            @(negedge clock);
            n++;
            quiet = (req_request == 4'b0) && !aux_request && (req_ack == 4'b0);
        end
        check_output(name, {31'b0, quiet}, 32'd1);
    endtask

    task automatic check_log(input string name, input int n, input int g0, input int g1, input int g2,
                             input int g3, input int g4, input int g5);
        int exp_g[6];
        exp_g = '{g0, g1, g2, g3, g4, g5};
        check_output({name, " grant count"}, grant_log.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < grant_log.size()) begin
                check_output($sformatf("%s grant[%0d]", name, k), grant_log[k], exp_g[k]);
            end
        end
    endtask

    // Target: acks the tgt_lat-th cycle of a transaction with address-based data.
    initial begin
        aux_ack   = 1'b0;
        aux_rdata = '0;
        forever begin
            @(posedge clock);
            #2;
            aux_ack   = 1'b0;
            aux_rdata = '0;
            if (aux_request === 1'b1) begin
                tgt_cnt++;
                if (tgt_en && tgt_cnt == tgt_lat) begin
                    aux_ack   = 1'b1;
                    aux_rdata = {8'hA5, aux_address};
                end
            end else begin
                tgt_cnt = 0;
            end
            if (force_ack) begin
                aux_ack   = 1'b1;
                aux_rdata = 32'h5A5A5A5A;
            end
        end
    end

    // Masters hold their request until they have received m_left acks.
    initial begin
        forever begin
            @(posedge clock);
            #2;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ack[i] === 1'b1 && m_left[i] > 0) begin
                    m_left[i]--;
                    if (m_left[i] == 0) req_request[i] = 1'b0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (req_ack !== 4'b0) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ack[i] === 1'b1) grant_log.push_back(i);
            end
            rdata_log.push_back(req_rdata);
        end
    end

    // Behavioural model: one transaction in flight, completion by ack or by
    // elapsed time, then one cycle where the result is shown and requests wait.
    bit          model_ready = 1'b0;
    int          cyc = 0;
    bit          busy = 1'b0;
    bit          showing = 1'b0;
    int          m_start = 0;
    int          m_master = 0;
    int          m_last_rr = NUM_REQ - 1;
    logic        e_aux_req = 1'b0;
    logic        e_write = 1'b0;
    logic [23:0] e_addr = '0;
    logic [31:0] e_wdata = '0;
    logic [3:0]  e_ack = '0;
    logic [31:0] e_rdata = '0;
    logic        e_err = 1'b0;

    always @(posedge clock) begin
        int winner;
        int j;
        bit set_err;
        cyc++;
        winner  = -1;
        set_err = 1'b0;
        if (reset) begin
            busy = 1'b0; showing = 1'b0; m_last_rr = NUM_REQ - 1;
            e_aux_req = 1'b0; e_write = 1'b0; e_addr = '0; e_wdata = '0;
            e_ack = '0; e_rdata = '0; e_err = 1'b0;
        end else begin
            e_ack = '0;
            if (showing) begin
                showing = 1'b0;
            end else if (busy) begin
                if (aux_ack || (cyc - m_start == TIMEOUT + 1)) begin
                    e_rdata   = aux_ack ? aux_rdata : 32'hDEADBEEF;
                    set_err   = !aux_ack;
                    e_ack     = 4'b0001 << m_master;
                    e_aux_req = 1'b0;
                    busy      = 1'b0;
                    showing   = 1'b1;
                end
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (winner < 0 && RT_MASK[i] && req_request[i]) winner = i;
                end
                for (int k = 1; k <= NUM_REQ; k++) begin
                    j = (m_last_rr + k) % NUM_REQ;
                    if (winner < 0 && !RT_MASK[j] && req_request[j]) begin
                        winner    = j;
                        m_last_rr = j;
                    end
                end
                if (winner >= 0) begin
                    busy      = 1'b1;
                    m_start   = cyc;
                    m_master  = winner;
                    e_aux_req = 1'b1;
                    e_write   = req_write[winner];
                    e_addr    = req_address[winner*24 +: 24];
                    e_wdata   = req_wdata[winner*32 +: 32];
                end
            end
            if (timeout_clear) e_err = 1'b0;
            if (set_err) e_err = 1'b1;
        end
        model_ready = 1'b1;
    end

    always @(negedge clock) begin
        if (model_ready) begin
            check_output("model aux_request", aux_request, e_aux_req);
            check_output("model req_ack", req_ack, e_ack);
            check_output("model timeout_error", timeout_error, e_err);
            if (e_aux_req) begin
                check_output("model aux_write", aux_write, e_write);
                check_output("model aux_address", aux_address, e_addr);
                check_output("model aux_wdata", aux_wdata, e_wdata);
            end
            if (e_ack != 4'b0) begin
                check_output("model req_rdata", req_rdata, e_rdata);
            end
        end
    end

    initial begin
        reset         = 1'b1;
        req_request   = '0;
        req_write     = '0;
        req_address   = '0;
        req_wdata     = '0;
        timeout_clear = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) m_left[i] = 0;

        repeat (2) sync();
        @(negedge clock);
        check_output("reset aux_request", aux_request, 32'd0);
        check_output("reset aux_write", aux_write, 32'd0);
        check_output("reset aux_address", aux_address, 32'd0);
        check_output("reset aux_wdata", aux_wdata, 32'd0);
        check_output("reset req_ack", req_ack, 32'd0);
        check_output("reset req_rdata", req_rdata, 32'd0);
        check_output("reset timeout_error", timeout_error, 32'd0);
        sync();
        reset = 1'b0;

        $display("[TB] single write from master 2");
        grant_log.delete(); rdata_log.delete();
        tgt_en = 1'b1; tgt_lat = 3;
        sync();
        apply_stimulus(2, 1'b1, 24'h000100, 32'h12345678, 1);
        @(negedge clock);
        check_output("write idle cycle aux_request", aux_request, 32'd0);
        @(negedge clock);
        check_output("write aux_request", aux_request, 32'd1);
        check_output("write aux_write", aux_write, 32'd1);
        check_output("write aux_address", aux_address, 32'h000100);
        check_output("write aux_wdata", aux_wdata, 32'h12345678);
        wait_quiet(40, "write completes");
        check_log("write", 1, 2, 0, 0, 0, 0, 0);

        $display("[TB] realtime priority, masters 0 and 1");
        grant_log.delete(); rdata_log.delete();
        tgt_lat = 2;
        sync();
        apply_stimulus(0, 1'b0, 24'h000010, 32'h0, 2);
        apply_stimulus(1, 1'b0, 24'h000111, 32'h0, 1);
        wait_quiet(60, "priority completes");
        check_log("priority", 3, 0, 0, 1, 0, 0, 0);

        $display("[TB] round-robin, masters 1 2 3");
        reset = 1'b1;
        repeat (2) sync();
        reset = 1'b0;
        grant_log.delete(); rdata_log.delete();
        apply_stimulus(1, 1'b0, 24'h000111, 32'h0, 2);
        apply_stimulus(2, 1'b0, 24'h000222, 32'h0, 2);
        apply_stimulus(3, 1'b0, 24'h000333, 32'h0, 2);
        wait_quiet(100, "round-robin completes");
        check_log("round-robin", 6, 1, 2, 3, 1, 2, 3);
        if (rdata_log.size() == 6) begin
            check_output("rr rdata[0]", rdata_log[0], 32'hA5000111);
            check_output("rr rdata[1]", rdata_log[1], 32'hA5000222);
            check_output("rr rdata[2]", rdata_log[2], 32'hA5000333);
            check_output("rr rdata[5]", rdata_log[5], 32'hA5000333);
        end else begin
            check_output("rr rdata count", rdata_log.size(), 32'd6);
        end

        $display("[TB] watchdog timeout on master 3");
        grant_log.delete(); rdata_log.delete();
        tgt_en = 1'b0;
        sync();
        apply_stimulus(3, 1'b0, 24'h000333, 32'h0, 1);
        wait_quiet(3 * TIMEOUT, "timeout completes");
        check_log("timeout", 1, 3, 0, 0, 0, 0, 0);
        if (rdata_log.size() > 0) check_output("timeout rdata", rdata_log[0], 32'hDEADBEEF);
        check_output("timeout_error set", timeout_error, 32'd1);
        repeat (5) @(negedge clock);
        check_output("timeout_error sticky", timeout_error, 32'd1);
        sync();
        timeout_clear = 1'b1;
        sync();
        timeout_clear = 1'b0;
        @(negedge clock);
        check_output("timeout_error cleared", timeout_error, 32'd0);

        $display("[TB] ack in the timeout cycle");
        grant_log.delete(); rdata_log.delete();
        tgt_en = 1'b1; tgt_lat = TIMEOUT + 1;
        sync();
        apply_stimulus(1, 1'b0, 24'h000111, 32'h0, 1);
        wait_quiet(3 * TIMEOUT, "tie completes");
        check_log("tie", 1, 1, 0, 0, 0, 0, 0);
        if (rdata_log.size() > 0) check_output("tie rdata", rdata_log[0], 32'hA5000111);
        check_output("tie timeout_error", timeout_error, 32'd0);

        $display("[TB] reset while master 1 is active");
        grant_log.delete(); rdata_log.delete();
        tgt_en = 1'b0;
        sync();
        apply_stimulus(1, 1'b1, 24'h000444, 32'hCAFEF00D, 1);
        repeat (4) sync();
        reset = 1'b1;
        sync();
        reset = 1'b0;
        tgt_en = 1'b1; tgt_lat = 2;
        @(negedge clock);
        check_output("mid reset aux_request", aux_request, 32'd0);
        check_output("mid reset aux_address", aux_address, 32'd0);
        check_output("mid reset aux_wdata", aux_wdata, 32'd0);
        check_output("mid reset aux_write", aux_write, 32'd0);
        check_output("mid reset req_ack", req_ack, 32'd0);
        check_output("mid reset ack log", grant_log.size(), 32'd0);
        wait_quiet(40, "post reset completes");
        check_log("post reset", 1, 1, 0, 0, 0, 0, 0);
        if (rdata_log.size() > 0) check_output("post reset rdata", rdata_log[0], 32'hA5000444);

        $display("[TB] stray ack while idle");
        grant_log.delete(); rdata_log.delete();
        sync();
        force_ack = 1'b1;
        sync();
        force_ack = 1'b0;
        repeat (3) @(negedge clock);
        check_output("stray ack req_ack", grant_log.size(), 32'd0);
        check_output("stray ack aux_request", aux_request, 32'd0);

        repeat (2) sync();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
